ascii_hex_parser: RTL and testbench

ASCII_HEX_PARSER -- requirements
Module: ascii_hex_parser

---
 rtl/ascii_hex_pkg.sv | 20 ++
 rtl/ascii_hex_classify.sv | 36 +++
 rtl/ascii_hex_parser.sv | 137 +++++++++++++
 tb/tb_ascii_hex_parser.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ascii_hex_pkg.sv
// Shared definitions for the ASCII hex entry parser.
// Holds the control-character codes and the parser state encoding.
// No logic; imported by ascii_hex_classify and ascii_hex_parser.
package ascii_hex_pkg;

    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_BS  = 8'h08;
    localparam logic [7:0] CHAR_DEL = 8'h7F;
    localparam logic [7:0] CHAR_ESC = 8'h1B;

    // IDLE: nothing typed; COLLECT: 1..NUM_DIGITS digits held;
    // DISCARD: entry poisoned, waiting for a terminator.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DISCARD = 2'd2
    } state_t;

endpackage

// File: rtl/ascii_hex_classify.sv
// Purpose: classify one received ASCII byte into hex digit / terminator / erase / escape.
// Latency: purely combinational, zero cycles.
// Backpressure: none; decodes whatever is on rx_data every cycle.
// Ports: rx_data in; nibble (digit value, only meaningful when is_hex),
//        is_hex, is_term (CR/LF), is_bs (BS/DEL), is_esc out.
//        A byte with all flags low is an invalid character.
module ascii_hex_classify
    import ascii_hex_pkg::*;
(
    input  logic [7:0] rx_data,
    output logic [3:0] nibble,
    output logic       is_hex,
    output logic       is_term,
    output logic       is_bs,
    output logic       is_esc
);

    always_comb begin
        nibble  = 4'h0;
        is_hex  = 1'b0;
        is_term = (rx_data == CHAR_CR) || (rx_data == CHAR_LF);
        is_bs   = (rx_data == CHAR_BS) || (rx_data == CHAR_DEL);
        is_esc  = (rx_data == CHAR_ESC);

        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_hex = 1'b1;
            nibble = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 yields 0xA..0xF.
            is_hex = 1'b1;
            nibble = rx_data[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/ascii_hex_parser.sv
// Purpose: build a hex value from typed ASCII characters with erase, escape and error handling.
// Latency: every output responds one cycle after the byte is sampled (all registered).
// Backpressure: none; one byte is consumed in every cycle rx_valid is high.
// Ports: clk, rst (sync active-high); rx_data/rx_valid byte input;
//        entry/digit_cnt live digits for display; value/value_valid last commit;
//        err pulse on invalid char or overflow; busy when not IDLE.
module ascii_hex_parser
    import ascii_hex_pkg::*;
#(
    parameter int NUM_DIGITS = 4
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [4*NUM_DIGITS-1:0] entry,
    output logic [3:0]              digit_cnt,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    value_valid,
    output logic                    err,
    output logic                    busy
);

    localparam int         ENTRY_W = 4 * NUM_DIGITS;
    localparam logic [3:0] MAX_CNT = 4'(NUM_DIGITS);

    logic [3:0] nibble;
    logic       is_hex;
    logic       is_term;
    logic       is_bs;
    logic       is_esc;

    state_t               state, state_n;
    logic [ENTRY_W-1:0]   entry_n;
    logic [3:0]           cnt_n;
    logic [ENTRY_W-1:0]   value_n;
    logic                 vv_n;
    logic                 err_n;

    ascii_hex_classify u_classify (
        .rx_data (rx_data),
        .nibble  (nibble),
        .is_hex  (is_hex),
        .is_term (is_term),
        .is_bs   (is_bs),
        .is_esc  (is_esc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            entry       <= '0;
            digit_cnt   <= 4'd0;
            value       <= '0;
            value_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            entry       <= entry_n;
            digit_cnt   <= cnt_n;
            value       <= value_n;
            value_valid <= vv_n;
            err         <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        entry_n = entry;
        cnt_n   = digit_cnt;
        value_n = value;
        vv_n    = 1'b0;
        err_n   = 1'b0;

        if (rx_valid) begin
            if (is_esc) begin
                state_n = IDLE;
                entry_n = '0;
                cnt_n   = 4'd0;
            end else begin
                case (state)
                    IDLE, COLLECT: begin
                        if (is_hex) begin
                            if (digit_cnt == MAX_CNT) begin
                                // Overflow poisons the whole entry.
                                err_n   = 1'b1;
                                entry_n = '0;
                                cnt_n   = 4'd0;
                                state_n = DISCARD;
                            end else begin
                                entry_n = (entry << 4) | ENTRY_W'(nibble);
                                cnt_n   = digit_cnt + 4'd1;
                                state_n = COLLECT;
                            end
                        end else if (is_term) begin
                            // A bare terminator in IDLE is ignored so CR LF commits once.
                            if (state == COLLECT) begin
                                value_n = entry;
                                vv_n    = 1'b1;
                                entry_n = '0;
                                cnt_n   = 4'd0;
                                state_n = IDLE;
                            end
                        end else if (is_bs) begin
                            if (state == COLLECT) begin
                                entry_n = entry >> 4;
                                cnt_n   = digit_cnt - 4'd1;
                                if (digit_cnt == 4'd1) begin
                                    state_n = IDLE;
                                end
                            end
                        end else begin
                            err_n   = 1'b1;
                            entry_n = '0;
                            cnt_n   = 4'd0;
                            state_n = DISCARD;
                        end
                    end
                    DISCARD: begin
                        // Only a terminator ends a poisoned entry; everything else is silent.
                        if (is_term) begin
                            state_n = IDLE;
                        end
                    end
                    default: begin
                        state_n = IDLE;
                        entry_n = '0;
                        cnt_n   = 4'd0;
                    end
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Purpose: self-checking bench for ascii_hex_parser (directed scenarios then random bytes).
// Latency: outputs are compared 1 time unit after each rising edge.
// Backpressure: none; bytes are driven back-to-back or with idle gaps.
module tb_ascii_hex_parser;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [W-1:0] entry;
    logic [3:0]   digit_cnt;
    logic [W-1:0] value;
    logic         value_valid;
    logic         err;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    // Reference model: typed digits as a list plus a poisoned flag.
    int           digs[$];
    bit           poisoned;
    logic [W-1:0] m_value;
    bit           m_vv;
    bit           m_err;

    ascii_hex_parser #(.NUM_DIGITS(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .entry       (entry),
        .digit_cnt   (digit_cnt),
        .value       (value),
        .value_valid (value_valid),
        .err         (err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] digits_value();
        logic [W-1:0] v = '0;
        foreach (digs[i]) v = W'((v * 16) + digs[i]);
        return v;
    endfunction

    // Apply one accepted byte to the model using the character rules directly.
    task automatic model_byte(input logic [7:0] b);
        int  d;
        bit  hex, term, bs, esc;
        hex  = 0;
        d    = 0;
        if (b >= "0" && b <= "9") begin hex = 1; d = int'(b) - 48; end
        if (b >= "A" && b <= "F") begin hex = 1; d = int'(b) - 65 + 10; end
        if (b >= "a" && b <= "f") begin hex = 1; d = int'(b) - 97 + 10; end
        term = (b == 8'h0D) || (b == 8'h0A);
        bs   = (b == 8'h08) || (b == 8'h7F);
        esc  = (b == 8'h1B);
        m_vv  = 0;
        m_err = 0;
        if (esc) begin
            digs.delete();
            poisoned = 0;
        end else if (poisoned) begin
            if (term) poisoned = 0;
        end else if (hex) begin
            if (digs.size() == N) begin
                m_err = 1; digs.delete(); poisoned = 1;
            end else begin
                digs.push_back(d);
            end
        end else if (term) begin
            if (digs.size() > 0) begin
                m_value = digits_value();
                m_vv    = 1;
                digs.delete();
            end
        end else if (bs) begin
            if (digs.size() > 0) void'(digs.pop_back());
        end else begin
            m_err = 1; digs.delete(); poisoned = 1;
        end
    endtask

    task automatic check_all();
        check("value_valid", 32'(value_valid), 32'(m_vv));
        check("err",         32'(err),         32'(m_err));
        check("entry",       32'(entry),       32'(digits_value()));
        check("digit_cnt",   32'(digit_cnt),   32'(digs.size()));
        check("value",       32'(value),       32'(m_value));
        check("busy",        32'(busy),        32'(poisoned || digs.size() > 0));
    endtask

    // One clock cycle: drive at the falling edge, compare just after the rising edge.
    task automatic step(input logic v, input logic [7:0] b);
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = v;
        rx_data  = b;
        @(posedge clk);
        #1;
        step_no++;
        if (v) model_byte(b);
        else begin m_vv = 0; m_err = 0; end
        check_all();
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
    endtask

    // Reset with a live byte on the bus: the byte must be dropped.
    task automatic reset_with_byte(input logic [7:0] b);
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        step_no++;
        digs.delete();
        poisoned = 0;
        m_value  = '0;
        m_vv     = 0;
        m_err    = 0;
        check_all();
    endtask

    function automatic logic [7:0] rand_hex_char();
        int d = $urandom_range(0, 15);
        if (d < 10) return 8'(48 + d);
        return ($urandom_range(0, 1) != 0) ? 8'(65 + d - 10) : 8'(97 + d - 10);
    endfunction

    function automatic logic [7:0] rand_byte();
        int p = $urandom_range(0, 19);
        if (p < 11) return rand_hex_char();
        if (p < 13) return ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
        if (p < 15) return ($urandom_range(0, 1) != 0) ? 8'h08 : 8'h7F;
        if (p == 15) return 8'h1B;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        m_value  = '0;
        poisoned = 0;

        // Reset state.
        reset_with_byte(8'h00);
        reset_with_byte("7");

        // "1a F3" CR commits 0x1AF3.
        send("1"); send("a"); send("F"); send("3"); send(8'h0D);
        check("s1_value", 32'(value), 32'h1AF3);
        check("s1_pulse", 32'(value_valid), 32'd1);
        step(1'b0, 8'h00);

        // Five digits overflow; CR ends discard with no commit.
        send("1"); send("2"); send("3"); send("4"); send("5");
        check("s2_err", 32'(err), 32'd1);
        send(8'h0D);
        check("s2_hold", 32'(value), 32'h1AF3);

        // Invalid 'G' poisons; '7' ignored.
        send("4"); send("G"); send("7"); send(8'h0D);

        // Backspace then commit 0x00AC; lone CR LF are silent.
        send("A"); send("B"); send(8'h08); send("C"); send(8'h0D);
        check("s4_value", 32'(value), 32'h00AC);
        send(8'h0D); send(8'h0A);

        // Backspace to empty then CR: no commit.
        send("7"); send(8'h7F); send(8'h0D);

        // Escape, then reset carrying '5'.
        send("9"); send("9"); send(8'h1B);
        reset_with_byte("5");
        step(1'b0, 8'h00);

        // Back-to-back DEAD CR.
        send("D"); send("E"); send("A"); send("D"); send(8'h0D);
        check("s6_value", 32'(value), 32'hDEAD);

        // Random traffic with gaps and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            int r = $urandom_range(0, 99);
            if (r == 0) reset_with_byte(rand_byte());
            else if (r < 15) step(1'b0, rand_byte());
            else send(rand_byte());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
